// File: rtl/graph_line_draw_if.sv
// Command/pixel bus between the line/clear engine, its command source and the framebuffer port.
// Latency: none, plain wires grouped for port convenience.
// Backpressure: grant_i from the video timing block gates framebuffer writes.
interface graph_line_draw_if;
  // command side
  logic       start_i;
  logic       cmd_i;
  logic [8:0] x0_i;
  logic [8:0] x1_i;
  logic [7:0] y0_i;
  logic [7:0] y1_i;
  logic [3:0] color_i;
  // framebuffer side
  logic       grant_i;
  logic       busy_o;
  logic       done_o;
  logic       fb_we_o;
  logic [9:0] fb_xloc_o;
  logic [8:0] fb_yloc_o;
  logic [3:0] fb_pal_o;

  // driver of commands and grant (command source plus video timing)
  modport master (
    output start_i, cmd_i, x0_i, x1_i, y0_i, y1_i, color_i, grant_i,
    input  busy_o, done_o, fb_we_o, fb_xloc_o, fb_yloc_o, fb_pal_o
  );

  // the drawing engine itself
  modport slave (
    input  start_i, cmd_i, x0_i, x1_i, y0_i, y1_i, color_i, grant_i,
    output busy_o, done_o, fb_we_o, fb_xloc_o, fb_yloc_o, fb_pal_o
  );
endinterface

// File: rtl/graph_line_draw.sv
// Rasterises a Bresenham line or clears the 320x240 plane into the 640x480 framebuffer write port.
// Latency: first pixel presented the cycle after start; done_o pulses the cycle after the last write.
// Backpressure: a pixel is written only when grant_i=1; with grant_i=0 the current pixel is held.
module graph_line_draw #(
  parameter int XMAX = 319,
  parameter int YMAX = 239
) (
  input logic          clk,
  input logic          rst_n,
  graph_line_draw_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LINE  = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [8:0] XLIM = XMAX[8:0];
  localparam logic [7:0] YLIM = YMAX[7:0];

  logic [1:0]         state;
  logic [8:0]         x;
  logic [7:0]         y;
  logic [8:0]         x_end;
  logic [7:0]         y_end;
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic signed [10:0] err;
  logic               sx_neg;
  logic               sy_neg;
  logic [3:0]         color;

  logic [8:0]         x0_c;
  logic [8:0]         x1_c;
  logic [7:0]         y0_c;
  logic [7:0]         y1_c;
  logic               sx_neg_init;
  logic               sy_neg_init;
  logic signed [10:0] dx_init;
  logic signed [10:0] dy_init;

  logic signed [10:0] e2;
  logic               step_x;
  logic               step_y;
  logic signed [10:0] err_nxt;
  logic               line_last;
  logic               clear_last;
  logic               busy;
  logic               accept;

  // Clamp endpoints into the 320x240 plane and derive the line setup terms.
  always_comb begin
    x0_c        = (bus.x0_i > XLIM) ? XLIM : bus.x0_i;
    x1_c        = (bus.x1_i > XLIM) ? XLIM : bus.x1_i;
    y0_c        = (bus.y0_i > YLIM) ? YLIM : bus.y0_i;
    y1_c        = (bus.y1_i > YLIM) ? YLIM : bus.y1_i;
    sx_neg_init = (x1_c < x0_c);
    sy_neg_init = (y1_c < y0_c);
    dx_init     = sx_neg_init ? $signed({2'b00, x0_c - x1_c})
                              : $signed({2'b00, x1_c - x0_c});
    dy_init     = sy_neg_init ? -$signed({3'b000, y0_c - y1_c})
                              : -$signed({3'b000, y1_c - y0_c});
  end

  // Bresenham step decision; both tests look at the error before this step's update.
  always_comb begin
    e2      = err <<< 1;
    step_x  = (e2 >= dy);
    step_y  = (e2 <= dx);
    err_nxt = err + (step_x ? dy : 11'sd0) + (step_y ? dx : 11'sd0);
  end

  assign line_last  = (x == x_end) && (y == y_end);
  assign clear_last = (x == XLIM) && (y == YLIM);
  assign busy       = (state == S_LINE) || (state == S_CLEAR);
  assign accept     = bus.start_i && ((state == S_IDLE) || (state == S_DONE));

  // Command sequencing: a new command is taken from IDLE or straight out of DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start_i) state <= bus.cmd_i ? S_CLEAR : S_LINE;
          else             state <= S_IDLE;
        end
        S_LINE: begin
          if (bus.grant_i && line_last) state <= S_DONE;
        end
        S_CLEAR: begin
          if (bus.grant_i && clear_last) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pixel position and error term: loaded at capture, advanced only on granted cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x      <= '0;
      y      <= '0;
      x_end  <= '0;
      y_end  <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
      color  <= '0;
    end else if (accept) begin
      color <= bus.color_i;
      if (bus.cmd_i) begin
        x <= '0;
        y <= '0;
      end else begin
        x      <= x0_c;
        y      <= y0_c;
        x_end  <= x1_c;
        y_end  <= y1_c;
        dx     <= dx_init;
        dy     <= dy_init;
        err    <= dx_init + dy_init;
        sx_neg <= sx_neg_init;
        sy_neg <= sy_neg_init;
      end
    end else if ((state == S_LINE) && bus.grant_i && !line_last) begin
      if (step_x) x <= sx_neg ? (x - 9'd1) : (x + 9'd1);
      if (step_y) y <= sy_neg ? (y - 8'd1) : (y + 8'd1);
      err <= err_nxt;
    end else if ((state == S_CLEAR) && bus.grant_i && !clear_last) begin
      if (x == XLIM) begin
        x <= '0;
        y <= y + 8'd1;
      end else begin
        x <= x + 9'd1;
      end
    end
  end

  // Framebuffer coordinates are the registered plane position doubled.
  assign bus.fb_xloc_o = {x, 1'b0};
  assign bus.fb_yloc_o = {y, 1'b0};
  assign bus.fb_pal_o  = color;
  assign bus.fb_we_o   = busy & bus.grant_i;
  assign bus.busy_o    = busy;
  assign bus.done_o    = (state == S_DONE);

endmodule

// File: tb/tb_graph_line_draw.sv
// Bench for graph_line_draw: directed lines, stalls, clamp, reset abort, full clear, random lines.
// Latency: checks first pixel in cycle 1 and done in the cycle after the last write.
// Backpressure: grant driven always-on, from a fixed pattern, or randomly.
module tb_graph_line_draw;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  graph_line_draw_if bus_if();

  graph_line_draw #(.XMAX(319), .YMAX(239)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];
  int obs_q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pk(input int xl, input int yl, input int p);
    return (xl << 13) | (yl << 4) | p;
  endfunction

  function automatic int clampi(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference line: integer Bresenham walk producing the expected framebuffer writes.
  function automatic void model_line(input int ax0, input int ay0, input int ax1, input int ay1,
                                     input int col);
    int x0, y0, x1, y1, x, y, dx, dy, sx, sy, err, e2;
    x0 = clampi(ax0, 319); x1 = clampi(ax1, 319);
    y0 = clampi(ay0, 239); y1 = clampi(ay1, 239);
    exp_q.delete();
    x = x0; y = y0;
    dx = absi(x1 - x0); dy = -absi(y1 - y0);
    sx = (x1 >= x0) ? 1 : -1; sy = (y1 >= y0) ? 1 : -1;
    err = dx + dy;
    for (int guard = 0; guard < 2000; guard++) begin
      exp_q.push_back(pk(2 * x, 2 * y, col));
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  // gmode: 0 grant always 1, 1 random grant, 2 pattern 1,0,0,1,1,0,1 then 1.
  // from_done: issue the command in the current (done) cycle instead of the next one.
  // poke: pulse start_i with junk inputs during cycles 2..3 of the operation.
  task automatic run_cmd(input bit cmd, input int ax0, input int ay0, input int ax1, input int ay1,
                         input int col, input int gmode, input bit from_done, input bit poke);
    int n_exp, k, cyc, cur, e, clr_bad;
    bit g;
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    obs_q.delete();
    if (!cmd) begin
      model_line(ax0, ay0, ax1, ay1, col);
      n_exp = absi(clampi(ax1, 319) - clampi(ax0, 319));
      if (absi(clampi(ay1, 239) - clampi(ay0, 239)) > n_exp)
        n_exp = absi(clampi(ay1, 239) - clampi(ay0, 239));
      n_exp = n_exp + 1;
    end else begin
      n_exp = 76800;
    end
    if (!from_done) begin
      @(posedge clk); #1;
    end
    bus_if.start_i = 1'b1;
    bus_if.cmd_i   = cmd;
    bus_if.x0_i    = 9'(ax0);
    bus_if.y0_i    = 8'(ay0);
    bus_if.x1_i    = 9'(ax1);
    bus_if.y1_i    = 8'(ay1);
    bus_if.color_i = 4'(col);
    bus_if.grant_i = 1'b0;
    if (!from_done) begin
      #3;
      chk("idle_busy", int'(bus_if.busy_o), 0);
      chk("idle_done", int'(bus_if.done_o), 0);
    end
    @(posedge clk); #1;
    // command inputs are don't-care while busy: scramble them
    bus_if.start_i = 1'b0;
    bus_if.cmd_i   = 1'($urandom);
    bus_if.x0_i    = 9'($urandom);
    bus_if.y0_i    = 8'($urandom);
    bus_if.x1_i    = 9'($urandom);
    bus_if.y1_i    = 8'($urandom);
    bus_if.color_i = 4'($urandom);
    cyc = 1; k = 0; clr_bad = 0;
    forever begin
      case (gmode)
        0:       g = 1'b1;
        1:       g = ($urandom_range(0, 3) != 0);
        default: g = (cyc <= 7) ? (pat[cyc - 1] != 0) : 1'b1;
      endcase
      bus_if.grant_i = g;
      bus_if.start_i = poke && (cyc == 2 || cyc == 3);
      #3;
      if (cyc == 1) chk("first_busy", int'(bus_if.busy_o), 1);
      if (!bus_if.busy_o) begin
        chk("done_pulse", int'(bus_if.done_o), 1);
        break;
      end
      if (bus_if.done_o) chk("done_while_busy", int'(bus_if.done_o), 0);
      cur = pk(int'(bus_if.fb_xloc_o), int'(bus_if.fb_yloc_o), int'(bus_if.fb_pal_o));
      if (k < n_exp) e = cmd ? pk(2 * (k % 320), 2 * (k / 320), col) : exp_q[k];
      else           e = -1;
      if (g) begin
        obs_q.push_back(cur);
        if (!cmd) begin
          chk("we", int'(bus_if.fb_we_o), 1);
          chk("pix", cur, e);
        end else if (cur != e || !bus_if.fb_we_o) begin
          clr_bad++;
        end
        k++;
      end else begin
        chk("stall_we", int'(bus_if.fb_we_o), 0);
        chk("stall_hold", cur, e);
      end
      if (cyc > 80000) begin
        chk("timeout", 0, 1);
        break;
      end
      cyc++;
      @(posedge clk); #1;
    end
    chk("count", k, n_exp);
    if (gmode == 0) chk("latency", cyc, n_exp + 1);
    if (cmd) chk("clear_px_bad", clr_bad, 0);
    bus_if.grant_i = 1'b0;
    bus_if.start_i = 1'b0;
  endtask

  initial begin
    int rx0, ry0, rx1, ry1;
    rst_n          = 1'b0;
    bus_if.start_i = 1'b0;
    bus_if.cmd_i   = 1'b0;
    bus_if.x0_i    = '0;
    bus_if.y0_i    = '0;
    bus_if.x1_i    = '0;
    bus_if.y1_i    = '0;
    bus_if.color_i = '0;
    bus_if.grant_i = 1'b1;
    #3;
    chk("rst_busy", int'(bus_if.busy_o), 0);
    chk("rst_done", int'(bus_if.done_o), 0);
    chk("rst_we",   int'(bus_if.fb_we_o), 0);
    chk("rst_loc",  pk(int'(bus_if.fb_xloc_o), int'(bus_if.fb_yloc_o), int'(bus_if.fb_pal_o)), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus_if.grant_i = 1'b0;

    // horizontal line
    run_cmd(1'b0, 0, 0, 3, 0, 5, 0, 1'b0, 1'b0);
    chk("h_n", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) chk("h_px", obs_q[i], pk(2 * i, 0, 5));

    // steep line issued in the done cycle of the previous one
    run_cmd(1'b0, 0, 0, 1, 3, 3, 0, 1'b1, 1'b0);
    chk("steep_n", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      chk("steep_p0", obs_q[0], pk(0, 0, 3));
      chk("steep_p1", obs_q[1], pk(0, 2, 3));
      chk("steep_p2", obs_q[2], pk(2, 4, 3));
      chk("steep_p3", obs_q[3], pk(2, 6, 3));
    end

    // reversed steep line
    run_cmd(1'b0, 1, 3, 0, 0, 4, 0, 1'b0, 1'b0);
    chk("rev_n", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      chk("rev_p0", obs_q[0], pk(2, 6, 4));
      chk("rev_p1", obs_q[1], pk(2, 4, 4));
      chk("rev_p2", obs_q[2], pk(0, 2, 4));
      chk("rev_p3", obs_q[3], pk(0, 0, 4));
    end

    // stalled horizontal line with start pulsed while busy
    run_cmd(1'b0, 0, 0, 3, 0, 5, 2, 1'b0, 1'b1);
    chk("stall_n", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) chk("stall_px", obs_q[i], pk(2 * i, 0, 5));

    // clamp + degenerate; y field is 8 bits so 250 stands in for an out-of-range y
    run_cmd(1'b0, 400, 250, 400, 250, 9, 0, 1'b0, 1'b0);
    chk("clamp_n", obs_q.size(), 1);
    if (obs_q.size() == 1) chk("clamp_px", obs_q[0], pk(638, 478, 9));

    // random short lines with random grant
    for (int t = 0; t < 16; t++) begin
      rx0 = $urandom_range(0, 340);
      ry0 = $urandom_range(0, 255);
      rx1 = rx0 + $urandom_range(0, 80) - 40;
      ry1 = ry0 + $urandom_range(0, 80) - 40;
      if (rx1 < 0) rx1 = 0;
      if (rx1 > 511) rx1 = 511;
      if (ry1 < 0) ry1 = 0;
      if (ry1 > 255) ry1 = 255;
      run_cmd(1'b0, rx0, ry0, rx1, ry1, $urandom_range(0, 15), 1, 1'b0, ($urandom_range(0, 1) == 1));
    end

    // reset in the middle of a 100-pixel line
    @(posedge clk); #1;
    bus_if.start_i = 1'b1; bus_if.cmd_i = 1'b0; bus_if.color_i = 4'd7;
    bus_if.x0_i = 9'd0; bus_if.y0_i = 8'd10; bus_if.x1_i = 9'd99; bus_if.y1_i = 8'd10;
    @(posedge clk); #1;
    bus_if.start_i = 1'b0; bus_if.grant_i = 1'b1;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(bus_if.busy_o), 0);
    chk("abort_done", int'(bus_if.done_o), 0);
    chk("abort_we",   int'(bus_if.fb_we_o), 0);
    chk("abort_loc",  pk(int'(bus_if.fb_xloc_o), int'(bus_if.fb_yloc_o), int'(bus_if.fb_pal_o)), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #3;
      chk("abort_no_done", int'(bus_if.done_o), 0);
    end
    #1 rst_n = 1'b1;
    bus_if.grant_i = 1'b0;
    run_cmd(1'b0, 10, 20, 30, 5, 11, 1, 1'b0, 1'b0);

    // full-screen clear
    run_cmd(1'b1, 0, 0, 0, 0, 2, 0, 1'b0, 1'b0);
    chk("clr_n", obs_q.size(), 76800);
    if (obs_q.size() == 76800) begin
      chk("clr_first", obs_q[0],     pk(0, 0, 2));
      chk("clr_320th", obs_q[319],   pk(638, 0, 2));
      chk("clr_last",  obs_q[76799], pk(638, 478, 2));
    end
    @(posedge clk); #3;
    chk("clr_done_drop", int'(bus_if.done_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
